// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared payload width and holding-slot operation codes for pipeline stage registers
package pipe_stage_reg_pkg;
  localparam int PAYLOAD_W = 87;
  typedef enum logic [1:0] {SLOT_HOLD, SLOT_LOAD, SLOT_UNLOAD, SLOT_CLEAR} slot_op_e;
endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: handshake bus between an upstream stage, the stage register and downstream
//   flush/in_valid/in_data/out_ready are driven by the surrounding pipeline (master)
//   in_ready/out_valid/out_data/bubble_cnt are driven by the stage register (slave)
interface pipe_stage_reg_if
  import pipe_stage_reg_pkg::*;
#(
  parameter int DATA_W = PAYLOAD_W,
  parameter int CNT_W  = 16
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  bubble_cnt;
  modport master (output flush, in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_data, bubble_cnt);
  modport slave  (input  flush, in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_data, bubble_cnt);
endinterface

// File: rtl/pipe_skid_slot.sv
// pipe_skid_slot: one valid+data holding register with load/unload/clear
//   clk, rst (sync, active-low), op_i selects hold/load/unload/clear,
//   d_i load data, valid_o/data_o held entry (data_o is NOP when empty)
module pipe_skid_slot
  import pipe_stage_reg_pkg::*;
#(
  parameter int           W   = PAYLOAD_W,
  parameter logic [W-1:0] NOP = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  slot_op_e     op_i,
  input  logic [W-1:0] d_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  always_comb begin
    valid_d = op_i == SLOT_LOAD ? 1'b1 : op_i == SLOT_HOLD ? valid_q : 1'b0;
    data_d  = op_i == SLOT_LOAD ? d_i  : op_i == SLOT_HOLD ? data_q  : NOP;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= NOP;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with valid/ready, flush, optional skid slot and bubble counter
//   clk, rst (sync, active-low), bus (slave side of pipe_stage_reg_if)
//   SKID=0: in_ready is combinational from out_ready; SKID=1: in_ready comes from the skid-slot flop
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W    = PAYLOAD_W,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter bit                SKID      = 1'b0,
  parameter int                CNT_W     = 16
) (
  input logic clk,
  input logic rst,
  pipe_stage_reg_if.slave bus
);
  logic              main_v, skid_v, accept, consume;
  logic [DATA_W-1:0] main_d, skid_d, main_src;
  slot_op_e          main_op;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  assign consume     = main_v && bus.out_ready;
  assign bus.in_ready = rst && (SKID ? !skid_v : (!main_v || bus.out_ready));
  assign accept      = bus.in_valid && bus.in_ready;
  // a waiting skid entry always refills the main register before new input does
  assign main_src    = skid_v ? skid_d : bus.in_data;
  always_comb begin
    main_op = bus.flush ? SLOT_CLEAR
            : (!main_v || consume) && (skid_v || accept) ? SLOT_LOAD
            : consume ? SLOT_UNLOAD : SLOT_HOLD;
    cnt_d   = !main_v && !(&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  end
  pipe_skid_slot #(.W(DATA_W), .NOP(NOP_VALUE)) u_main (
    .clk(clk), .rst(rst), .op_i(main_op), .d_i(main_src),
    .valid_o(main_v), .data_o(main_d)
  );
  if (SKID) begin : g_skid
    slot_op_e skid_op;
    // input lands here only when the main register is full and not draining
    always_comb
      skid_op = bus.flush ? SLOT_CLEAR
              : accept && main_v && !consume ? SLOT_LOAD
              : consume ? SLOT_UNLOAD : SLOT_HOLD;
    pipe_skid_slot #(.W(DATA_W), .NOP(NOP_VALUE)) u_skid (
      .clk(clk), .rst(rst), .op_i(skid_op), .d_i(bus.in_data),
      .valid_o(skid_v), .data_o(skid_d)
    );
  end else begin : g_noskid
    assign skid_v = 1'b0;
    assign skid_d = NOP_VALUE;
  end
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign bus.out_valid  = main_v;
  assign bus.out_data   = main_d;
  assign bus.bubble_cnt = cnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: three stage registers (SKID=0, SKID=1, SKID=1 with 4-bit counter) against a FIFO model
module tb_pipe_stage_reg;
  localparam int W = 87;
  localparam logic [W-1:0] NOP = 87'hABC;
  logic clk = 0, rst = 0, flush = 0, out_ready = 1, man_valid = 0, mode = 0, src_load = 0, go = 0;
  logic [W-1:0] man_data = '0, base = '0;
  int lim = 0, total = 0, bad = 0;
  int sent[3];
  logic iv[3], ov[3], rdy[3];
  logic [W-1:0] id[3], od[3];
  logic [15:0] bc[3];
  logic [W-1:0] mq[3][2];
  int mn[3], mbc[3];
  always #5 clk = ~clk;
  pipe_stage_reg_if #(.DATA_W(W), .CNT_W(16)) b0 ();
  pipe_stage_reg_if #(.DATA_W(W), .CNT_W(16)) b1 ();
  pipe_stage_reg_if #(.DATA_W(W), .CNT_W(4))  b2 ();
  pipe_stage_reg #(.DATA_W(W), .NOP_VALUE(NOP), .SKID(1'b0), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .bus(b0));
  pipe_stage_reg #(.DATA_W(W), .NOP_VALUE(NOP), .SKID(1'b1), .CNT_W(16)) u1 (.clk(clk), .rst(rst), .bus(b1));
  pipe_stage_reg #(.DATA_W(W), .NOP_VALUE(NOP), .SKID(1'b1), .CNT_W(4))  u2 (.clk(clk), .rst(rst), .bus(b2));
  assign b0.flush = flush; assign b0.in_valid = iv[0]; assign b0.in_data = id[0]; assign b0.out_ready = out_ready;
  assign b1.flush = flush; assign b1.in_valid = iv[1]; assign b1.in_data = id[1]; assign b1.out_ready = out_ready;
  assign b2.flush = flush; assign b2.in_valid = iv[2]; assign b2.in_data = id[2]; assign b2.out_ready = out_ready;
  assign ov[0] = b0.out_valid; assign od[0] = b0.out_data; assign rdy[0] = b0.in_ready; assign bc[0] = b0.bubble_cnt;
  assign ov[1] = b1.out_valid; assign od[1] = b1.out_data; assign rdy[1] = b1.in_ready; assign bc[1] = b1.bubble_cnt;
  assign ov[2] = b2.out_valid; assign od[2] = b2.out_data; assign rdy[2] = b2.in_ready; assign bc[2] = {12'd0, b2.bubble_cnt};
  // per-instance upstream source: either a shared manual vector or an auto-advancing counter
  always_comb
    for (int i = 0; i < 3; i++) begin
      iv[i] = mode ? (sent[i] < lim) : man_valid;
      id[i] = mode ? base + W'(sent[i] + 1) : man_data;
    end
  always @(posedge clk)
    for (int i = 0; i < 3; i++)
      if (src_load) sent[i] <= 0;
      else if (mode && iv[i] && rdy[i]) sent[i] <= sent[i] + 1;
  function automatic bit is_skid(input int i); return i != 0; endfunction
  function automatic int max_bc(input int i); return i == 2 ? 15 : 65535; endfunction
  function automatic logic exp_rdy(input int i);
    return rst && (is_skid(i) ? mn[i] < 2 : (mn[i] == 0 || out_ready));
  endfunction
  // model: each stage is a FIFO of depth 1 (SKID=0) or 2 (SKID=1)
  always @(posedge clk)
    for (int i = 0; i < 3; i++) begin
      automatic logic acc = iv[i] && exp_rdy(i);
      automatic logic con = mn[i] > 0 && out_ready;
      if (!rst) begin
        mn[i] = 0; mbc[i] = 0;
      end else begin
        if (mn[i] == 0 && mbc[i] < max_bc(i)) mbc[i]++;
        if (flush) mn[i] = 0;
        else begin
          if (con) begin mq[i][0] = mq[i][1]; mn[i]--; end
          if (acc) begin mq[i][mn[i]] = id[i]; mn[i]++; end
        end
      end
    end
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask
  always @(negedge clk)
    if (go)
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d_out_valid", i), W'(ov[i]), W'(mn[i] > 0));
        chk($sformatf("u%0d_out_data", i), od[i], mn[i] > 0 ? mq[i][0] : NOP);
        chk($sformatf("u%0d_in_ready", i), W'(rdy[i]), W'(exp_rdy(i)));
        chk($sformatf("u%0d_bubble_cnt", i), W'(bc[i]), W'(mbc[i]));
      end
  task automatic tick; @(posedge clk); #1; endtask
  initial begin
    for (int i = 0; i < 3; i++) begin sent[i] = 0; mn[i] = 0; mbc[i] = 0; end
    man_valid = 1; man_data = W'(16'hBEEF);
    tick; go = 1;
    @(negedge clk);
    chk("rst_u0_valid", W'(ov[0]), 0); chk("rst_u0_data", od[0], NOP);
    chk("rst_u0_rdy", W'(rdy[0]), 0); chk("rst_u1_rdy", W'(rdy[1]), 0);
    chk("rst_u1_data", od[1], NOP); chk("rst_u0_bc", W'(bc[0]), 0);
    tick; tick;
    rst = 1; man_valid = 0;
    @(negedge clk);
    chk("rel_u0_rdy", W'(rdy[0]), 1); chk("rel_u1_rdy", W'(rdy[1]), 1); chk("rel_u0_bc", W'(bc[0]), 0);
    tick; chk("bc_1", W'(bc[0]), 1);
    tick; chk("bc_2", W'(bc[1]), 2);
    repeat (18) tick;
    chk("bc_20", W'(bc[0]), 20); chk("sat_15", W'(bc[2]), 15);
    tick;
    chk("bc_21", W'(bc[0]), 21); chk("sat_hold", W'(bc[2]), 15);
    for (int k = 1; k <= 8; k++) begin
      man_valid = 1; man_data = W'(k);
      tick;
      chk($sformatf("stream_u0_d%0d", k), od[0], W'(k)); chk($sformatf("stream_u1_d%0d", k), od[1], W'(k));
      chk("stream_u0_v", W'(ov[0]), 1); chk("stream_u0_bc", W'(bc[0]), 22); chk("stream_u1_bc", W'(bc[1]), 22);
    end
    man_valid = 0;
    tick; tick;
    src_load = 1; tick; src_load = 0;
    mode = 1; lim = 6; base = '0;
    for (int c = 1; c <= 12; c++) begin
      out_ready = (c < 3 || c > 5);
      @(negedge clk);
      if (c == 3) begin chk("bp_u0_rdy", W'(rdy[0]), 0); chk("bp_u1_rdy_skid", W'(rdy[1]), 1); end
      if (c == 4) chk("bp_u1_rdy_full", W'(rdy[1]), 0);
      if (c >= 3 && c <= 5) begin chk("bp_u0_hold", od[0], 2); chk("bp_u1_hold", od[1], 2); end
      tick;
    end
    chk("bp_u0_drained", W'(ov[0]), 0); chk("bp_u1_drained", W'(ov[1]), 0);
    mode = 0;
    out_ready = 0; man_valid = 1; man_data = 'h41; @(negedge clk); tick;
    man_data = 'h42; @(negedge clk); tick;
    man_data = 'h55; flush = 1; @(negedge clk);
    chk("fl_u1_rdy_full", W'(rdy[1]), 0); chk("fl_u1_pre", od[1], 'h41); tick;
    flush = 0; man_data = 'h43; @(negedge clk);
    chk("fl_u1_v", W'(ov[1]), 0); chk("fl_u1_nop", od[1], NOP); tick;
    man_data = 'h55; flush = 1; @(negedge clk);
    chk("fl_u1_rdy_kept", W'(rdy[1]), 1); chk("fl_u1_43", od[1], 'h43); tick;
    flush = 0; man_data = 'h66; out_ready = 1; @(negedge clk);
    chk("fl2_u1_v", W'(ov[1]), 0); chk("fl2_u1_nop", od[1], NOP); chk("fl2_u0_nop", od[0], NOP); tick;
    man_valid = 0; @(negedge clk);
    chk("fl_u0_66", od[0], 'h66); chk("fl_u1_66", od[1], 'h66); tick;
    tick;
    out_ready = 0; man_valid = 1; man_data = 'h71; tick;
    man_data = 'h72; tick;
    rst = 0; man_data = 'h73; @(negedge clk);
    chk("rs_u1_rdy", W'(rdy[1]), 0); chk("rs_u1_pre", od[1], 'h71); tick;
    rst = 1; man_valid = 0; out_ready = 1; @(negedge clk);
    chk("rs_u1_v", W'(ov[1]), 0); chk("rs_u1_nop", od[1], NOP); chk("rs_u1_bc", W'(bc[1]), 0); chk("rs_u1_rdy1", W'(rdy[1]), 1);
    tick; @(negedge clk);
    chk("rs_u1_empty", W'(ov[1]), 0); chk("rs_u0_bc1", W'(bc[0]), 1);
    tick; tick;
    go = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register carrying the packed control and data payload between two CPU pipeline stages.
- Generalises the fixed MEM/WB latch with:
  - valid/ready handshake
  - synchronous flush that inserts a bubble
  - optional two-entry skid buffer that breaks the combinational ready path
  - saturating bubble counter for performance debug
- One instance sits on each stage boundary: IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
- DATA_W, 87, width of the packed stage payload (control ops, PC, IH, ALU result, RAM data, WB address).
- NOP_VALUE, 0, payload driven on out_data whenever the stage holds a bubble.
- SKID, 0, 0 = single register with combinational in_ready; 1 = two-entry skid buffer with registered in_ready.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low: stage resets on any clk edge where rst==0.
- flush  in  1  discard all held and incoming payload this cycle.
- in_valid  in  1  upstream presents a payload.
- in_ready  out  1  stage accepts the payload this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  stage holds a payload for downstream.
- out_ready  in  1  downstream consumes the payload this cycle.
- out_data  out  DATA_W  held payload; equals NOP_VALUE when out_valid==0.
- bubble_cnt  out  CNT_W  number of cycles with out_valid==0 since reset, saturating.

Behaviour:
- Reset (rst==0 at clk edge):
  - out_valid=0, out_data=NOP_VALUE, bubble_cnt=0, skid slot empty.
  - in_ready=0 while rst==0.
  - in_ready=1 from the first cycle after rst returns to 1.
  - Reset has priority over flush and over any handshake.
- Transfers:
  - Accept = in_valid && in_ready.
  - Consume = out_valid && out_ready.
  - in_data and in_valid are don't-care when in_ready==0.
- Latency: one cycle. A payload accepted at edge N is on out_data with out_valid=1 after edge N.
- SKID=0:
  - in_ready = !out_valid || out_ready (combinational).
  - Simultaneous consume and accept replaces the payload with no bubble, giving full throughput.
- SKID=1:
  - in_ready = !skid_valid, driven straight from a flop.
  - If accept occurs while out_valid && !out_ready, the payload goes to the skid slot.
  - When the main register is consumed, the skid content moves to the main register on the same edge.
  - A new accept on that same edge is legal only if the skid slot was empty.
  - Order is strictly FIFO: out_data never reorders, drops or duplicates payloads.
- Stall (out_ready==0 with out_valid==1): out_data and out_valid stay bit-stable.
- Flush (flush==1, rst==1):
  - On the next edge out_valid=0, out_data=NOP_VALUE and the skid slot is emptied.
  - A same-cycle accept is dropped: flush beats accept.
  - in_ready is unaffected by flush.
  - Consume in the flush cycle still counts as a consume by downstream.
- Bubble counter:
  - bubble_cnt increments on every edge with rst==1 where the registered out_valid==0.
  - It holds at 2^CNT_W-1.
  - Flush does not clear it.
- out_data changes only on clk edges, never combinationally from in_data.

Decomposition:
- Shared definitions include (the existing global defines file):
  - payload field widths and bus macros (DATA_BUS, REG_ADDR_BUS, WB_DATA_OP_BUS, REG_OP_BUS)
  - per-boundary DATA_W constants
  - per-boundary NOP payload constants, e.g. MEM/WB NOP = WB op "none", reg op "no write"
- Payload pack/unpack is done by the instantiating stage, not by this block.
- One sub-module, pipe_skid_slot: a single valid+data holding register with load/unload/clear. It is instantiated once for the main register and, when SKID=1, once more for the skid slot.

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_valid=1, in_data=16'hBEEF in the low bits, then release. Expect:
  - out_valid=0, out_data=NOP_VALUE and in_ready=0 during reset.
  - in_ready=1 on the first cycle after release.
  - bubble_cnt counting 1,2,… from that point.
- Streaming (SKID=0 and SKID=1): send payloads 1..8 back-to-back with out_ready=1. Expect:
  - out_data sequence 1..8 starting one cycle after the first accept.
  - out_valid continuously 1 for 8 cycles.
  - bubble_cnt frozen during the burst.
- Backpressure: stream 1..6 while out_ready=0 for cycles 3–5. Expect:
  - out_data held stable.
  - SKID=0: in_ready=0 while out_valid=1 and out_ready=0.
  - SKID=1: one extra payload absorbed into the skid slot, then in_ready=0.
  - Final output order exactly 1..6 with none lost.
- Flush priority: flush=1 in the same cycle as accept of payload 0x55 with a full skid slot (SKID=1). Expect:
  - next cycle out_valid=0 and out_data=NOP_VALUE.
  - 0x55 and the skid contents never appear on out_data.
  - the following accept of 0x66 appears normally.
- Reset mid-stall: out_valid=1 with skid full, out_ready=0, then rst=0 for 1 cycle. Expect the full reset state on the next edge and both entries discarded.
- Counter saturation with CNT_W=4: idle for 20 cycles. Expect bubble_cnt to reach 15 and hold at 15.
